// File: rtl/bip_uart_if.sv
// Serial pin pair between a UART host and the BIP board: h2d is host->device, d2h is device->host.
interface bip_uart_if;
  logic h2d;
  logic d2h;

  modport host (output h2d, input d2h);
  modport dev  (input h2d, output d2h);
endinterface

// File: rtl/bip_uart_top.sv
// BIP accumulator processor with a UART trigger: any received byte runs the ROM program once,
// then ACC and the executed-instruction count are reported back as four UART bytes.
module bip_uart_top #(
  parameter int DATA_WIDTH     = 16,
  parameter int UART_DATA_SIZE = 8,
  parameter int INS_MEM_DEPTH  = 2048,
  parameter int DATA_MEM_DEPTH = 2048,
  parameter int NB_SIGX        = 11,
  parameter int BAUD_DIV       = 25,
  parameter logic [8*DATA_WIDTH-1:0] PROG = {16'h0000, 16'h0000, 16'h2000, 16'h3801,
                                             16'h1000, 16'h0800, 16'h2803, 16'h1805}
) (
  input  logic i_clk,
  input  logic BTNC,
  input  logic UART_TXD_IN,
  output logic UART_RXD_OUT
);
  localparam int PC_W  = $clog2(INS_MEM_DEPTH);
  localparam int BC_W  = $clog2(BAUD_DIV);
  localparam int TC_W  = $clog2(16 * BAUD_DIV);
  localparam int BIT_W = $clog2(UART_DATA_SIZE);
  localparam logic [BC_W-1:0]  BMAX = BC_W'(BAUD_DIV - 1);
  localparam logic [TC_W-1:0]  TMAX = TC_W'(16 * BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST = BIT_W'(UART_DATA_SIZE - 1);

  // ---------------- UART receiver (trigger only, byte value discarded)
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
  rx_t              rx_q, rx_d;
  logic [1:0]       sync_q;
  logic             rx_prev_q, rx_done_q, rx_done_d, btick, rx_s;
  logic [BC_W-1:0]  bcnt_q;
  logic [3:0]       stk_q, stk_d;
  logic [BIT_W-1:0] rbit_q, rbit_d;

  assign rx_s  = sync_q[1];
  assign btick = (bcnt_q == BMAX);

  always_comb begin
    rx_d = rx_q; stk_d = stk_q; rbit_d = rbit_q; rx_done_d = 1'b0;
    unique case (rx_q)
      RX_IDLE: if (rx_prev_q && !rx_s) begin
        rx_d  = RX_START;
        stk_d = '0;
      end
      default: if (btick) begin
        stk_d = stk_q + 4'd1;
        if (rx_q == RX_START && stk_q == 4'd7) begin
          stk_d  = '0;
          rbit_d = '0;
          rx_d   = rx_s ? RX_IDLE : RX_DATA;
        end else if (rx_q == RX_DATA && stk_q == 4'd15) begin
          rbit_d = rbit_q + 1'b1;
          if (rbit_q == LAST) rx_d = RX_STOP;
        end else if (rx_q == RX_STOP && stk_q == 4'd15) begin
          rx_done_d = rx_s;  // a low stop bit silently drops the frame
          rx_d      = RX_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (BTNC) begin
      rx_q <= RX_IDLE; sync_q <= 2'b11; rx_prev_q <= 1'b1; rx_done_q <= 1'b0;
      bcnt_q <= '0; stk_q <= '0; rbit_q <= '0;
    end else begin
      rx_q <= rx_d; sync_q <= {sync_q[0], UART_TXD_IN}; rx_prev_q <= rx_s;
      rx_done_q <= rx_done_d; stk_q <= stk_d; rbit_q <= rbit_d;
      bcnt_q <= btick ? '0 : bcnt_q + 1'b1;
    end
  end

  // ---------------- UART transmitter
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_t;
  tx_t                       tx_q, tx_d;
  logic [TC_W-1:0]           tcnt_q, tcnt_d;
  logic [BIT_W-1:0]          tbit_q, tbit_d;
  logic [UART_DATA_SIZE-1:0] tsh_q, tsh_d, tx_byte;
  logic                      txd_q, txd_d, tx_start, tx_done, bit_end;

  assign bit_end      = (tcnt_q == TMAX);
  assign UART_RXD_OUT = txd_q;

  always_comb begin
    tx_d = tx_q; tcnt_d = tcnt_q + 1'b1; tbit_d = tbit_q; tsh_d = tsh_q;
    txd_d = txd_q; tx_done = 1'b0;
    unique case (tx_q)
      TX_IDLE: begin
        txd_d  = 1'b1;
        tcnt_d = '0;
        if (tx_start) begin
          tx_d  = TX_START;
          tsh_d = tx_byte;
          txd_d = 1'b0;
        end
      end
      TX_START: if (bit_end) begin
        tx_d = TX_DATA; tcnt_d = '0; tbit_d = '0; txd_d = tsh_q[0];
      end
      TX_DATA: if (bit_end) begin
        tcnt_d = '0;
        if (tbit_q == LAST) begin
          tx_d  = TX_STOP;
          txd_d = 1'b1;
        end else begin
          tbit_d = tbit_q + 1'b1;
          tsh_d  = tsh_q >> 1;
          txd_d  = tsh_q[1];
        end
      end
      default: if (bit_end) begin
        tx_d    = TX_IDLE;
        tx_done = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (BTNC) begin
      tx_q <= TX_IDLE; tcnt_q <= '0; tbit_q <= '0; txd_q <= 1'b1;
    end else begin
      tx_q <= tx_d; tcnt_q <= tcnt_d; tbit_q <= tbit_d; txd_q <= txd_d;
    end
  end

  always_ff @(posedge i_clk) tsh_q <= tsh_d;

  // ---------------- Processor and control FSM
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SEND} st_t;
  st_t                   st_q, st_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d, cnt_q, cnt_d, instr, mem_rd, sx_op;
  logic [1:0]            idx_q, idx_d;
  logic [4:0]            opc;
  logic [NB_SIGX-1:0]    opnd;
  logic                  dm_we;
  logic [DATA_WIDTH-1:0] dmem [DATA_MEM_DEPTH];

  // Only the first eight ROM words are programmable; the rest read as HLT.
  assign instr  = (pc_q < PC_W'(8)) ? PROG[32'(pc_q[2:0]) * DATA_WIDTH +: DATA_WIDTH] : '0;
  assign opc    = instr[DATA_WIDTH-1 -: 5];
  assign opnd   = instr[NB_SIGX-1:0];
  assign sx_op  = {{(DATA_WIDTH-NB_SIGX){opnd[NB_SIGX-1]}}, opnd};
  assign mem_rd = dmem[opnd];

  always_comb begin
    unique case (idx_q)
      2'd0:    tx_byte = acc_q[7:0];
      2'd1:    tx_byte = acc_q[15:8];
      2'd2:    tx_byte = cnt_q[7:0];
      default: tx_byte = cnt_q[15:8];
    endcase
  end

  always_comb begin
    st_d = st_q; pc_d = pc_q; acc_d = acc_q; cnt_d = cnt_q; idx_d = idx_q;
    dm_we = 1'b0; tx_start = 1'b0;
    unique case (st_q)
      S_IDLE: if (rx_done_q) begin
        st_d = S_RUN; pc_d = '0; acc_d = '0; cnt_d = '0;
      end
      S_RUN: begin
        pc_d  = pc_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
        case (opc)
          5'b00000: begin st_d = S_SEND; idx_d = '0; pc_d = pc_q; end
          5'b00001: dm_we = 1'b1;
          5'b00010: acc_d = mem_rd;
          5'b00011: acc_d = sx_op;
          5'b00100: acc_d = acc_q + mem_rd;
          5'b00101: acc_d = acc_q + sx_op;
          5'b00110: acc_d = acc_q - mem_rd;
          5'b00111: acc_d = acc_q - sx_op;
          default:  ;
        endcase
      end
      default: begin
        tx_start = (tx_q == TX_IDLE);
        if (tx_done) begin
          if (idx_q == 2'd3) st_d = S_IDLE;
          else               idx_d = idx_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (BTNC) begin
      st_q <= S_IDLE; pc_q <= '0; acc_q <= '0; cnt_q <= '0; idx_q <= '0;
    end else begin
      st_q <= st_d; pc_q <= pc_d; acc_q <= acc_d; cnt_q <= cnt_d; idx_q <= idx_d;
    end
  end

  always_ff @(posedge i_clk) if (dm_we) dmem[opnd] <= acc_q;
endmodule

// File: tb/tb_bip_uart_top.sv
// Directed bench for bip_uart_top: a default-ROM DUT and a wrap/sign-extension ROM DUT.
module tb_bip_uart_top;
  localparam int BIT = 400;

  logic clk = 1'b0;
  logic btnc;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  bip_uart_if uif ();
  bip_uart_if uif6 ();

  bip_uart_top u_dut (
    .i_clk(clk), .BTNC(btnc), .UART_TXD_IN(uif.h2d), .UART_RXD_OUT(uif.d2h)
  );

  bip_uart_top #(
    .PROG({16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h2801, 16'h1FFF})
  ) u_dut6 (
    .i_clk(clk), .BTNC(btnc), .UART_TXD_IN(uif6.h2d), .UART_RXD_OUT(uif6.d2h)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic line(input int d);
    return (d == 0) ? uif.d2h : uif6.d2h;
  endfunction

  task automatic drive(input int d, input logic v);
    if (d == 0) uif.h2d = v;
    else        uif6.h2d = v;
  endtask

  task automatic send_byte(input int d, input logic [7:0] b, input logic stop);
    drive(d, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(d, b[i]);
      repeat (BIT) @(negedge clk);
    end
    drive(d, stop);
    repeat (BIT) @(negedge clk);
    drive(d, 1'b1);
  endtask

  task automatic wait_low(input int d, input int tmo, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (line(d) == 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic rx_byte(input int d, input string tag, input logic [7:0] exp, input int tmo);
    logic seen, okf;
    logic [7:0] b;
    wait_low(d, tmo, seen);
    chk({tag, "_start"}, 16'(seen), 16'd1);
    if (seen) begin
      repeat (BIT/2) @(negedge clk);
      okf = ~line(d);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = line(d);
      end
      repeat (BIT) @(negedge clk);
      okf = okf & line(d);
      chk({tag, "_frame"}, 16'(okf), 16'd1);
      chk(tag, {8'h00, b}, {8'h00, exp});
    end
  endtask

  task automatic rx_report(input int d, input string tag, input logic [31:0] exp);
    rx_byte(d, {tag, "_acc_lo"}, exp[7:0],   6000);
    rx_byte(d, {tag, "_acc_hi"}, exp[15:8],  1000);
    rx_byte(d, {tag, "_cnt_lo"}, exp[23:16], 1000);
    rx_byte(d, {tag, "_cnt_hi"}, exp[31:24], 1000);
  endtask

  task automatic expect_quiet(input int d, input string tag, input int n);
    logic low;
    low = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (line(d) == 1'b0) low = 1'b1;
    end
    chk(tag, 16'(low), 16'd0);
  endtask

  initial begin
    logic seen;
    btnc = 1'b1;
    uif.h2d = 1'b1;
    uif6.h2d = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    btnc = 1'b0;
    chk("rst_tx", 16'(line(0)), 16'd1);
    chk("rst_tx6", 16'(line(1)), 16'd1);
    expect_quiet(0, "idle_10k", 10000);

    // Default program reports ACC=15, CNT=7; the second ROM wraps -1+1 to 0 with CNT=3.
    fork
      send_byte(0, 8'h38, 1'b1);
      rx_report(0, "run", 32'h0007_000F);
      send_byte(1, 8'h38, 1'b1);
      rx_report(1, "wrap", 32'h0003_0000);
    join
    expect_quiet(0, "run_done", 1000);

    // Bad stop bit on one DUT while the other receives a second trigger during SEND.
    fork
      begin
        send_byte(1, 8'h55, 1'b0);
        expect_quiet(1, "bad_stop", 2000);
      end
      begin
        send_byte(0, 8'h38, 1'b1);
        repeat (3000) @(negedge clk);
        send_byte(0, 8'hA5, 1'b1);
      end
      rx_report(0, "busy", 32'h0007_000F);
    join
    expect_quiet(0, "four_only", 1000);

    // Reset while the third report byte is on the wire, inside a zero data bit.
    fork
      send_byte(0, 8'h38, 1'b1);
      begin
        rx_byte(0, "pre_acc_lo", 8'h0F, 6000);
        rx_byte(0, "pre_acc_hi", 8'h00, 1000);
      end
    join
    wait_low(0, 1000, seen);
    chk("pre_cnt_start", 16'(seen), 16'd1);
    repeat (2200) @(negedge clk);
    chk("pre_rst_low", 16'(line(0)), 16'd0);
    btnc = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_abort", 16'(line(0)), 16'd1);
    repeat (3) @(negedge clk);
    btnc = 1'b0;
    expect_quiet(0, "post_rst", 1000);

    fork
      send_byte(0, 8'h38, 1'b1);
      rx_report(0, "after_rst", 32'h0007_000F);
    join
    expect_quiet(0, "end_quiet", 500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
